// File: rtl/fmac_sched.sv
// Run-time-length multiply-accumulate sequencer driving an external pipelined fmul and fadd.
// Issues one operand pair every ADD_LAT+2 cycles so the adder always sees the previous sum.
module fmac_sched #(
  parameter int WE      = 8,
  parameter int WF      = 23,
  parameter int MUL_LAT = 2,
  parameter int ADD_LAT = 1,
  parameter int CNT_W   = 16,
  localparam int W      = WE + WF + 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_elems,
  input  logic [W-1:0]     init_val,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  output logic [W-1:0]     fmul_x,
  output logic [W-1:0]     fmul_y,
  input  logic [W-1:0]     fmul_r,
  output logic [W-1:0]     fadd_x,
  output logic [W-1:0]     fadd_y,
  input  logic [W-1:0]     fadd_r,
  output logic             done,
  output logic [W-1:0]     result
);

  localparam int II   = ADD_LAT + 2;
  localparam int CD_W = $clog2(II);
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(II - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] n_reg, cnt, cnt_inc;
  logic [CD_W-1:0]  cool;
  logic [W-1:0]     acc;
  logic [MUL_LAT:0] mv, mv_nxt;
  logic [ADD_LAT:0] av, av_nxt;
  logic             accept, mul_tap, add_tap;

  assign in_ready = (state == RUN) && (cool == '0) && (cnt != n_reg);
  assign accept   = in_ready && in_valid;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign mul_tap  = mv[MUL_LAT];
  assign add_tap  = av[ADD_LAT];
  // Both latencies must be at least 1 for these shifts to be well formed.
  assign mv_nxt   = {mv[MUL_LAT-1:0], accept};
  assign av_nxt   = {av[ADD_LAT-1:0], mul_tap};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (n_elems == '0) ? DONE : RUN;
      RUN:   if (accept && (cnt_inc == n_reg)) state_nxt = DRAIN;
      // Leave as soon as the final accumulator write lands this cycle.
      DRAIN: if ((mv_nxt == '0) && (av_nxt == '0)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, DRAIN: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      n_reg  <= '0;
      cnt    <= '0;
      cool   <= '0;
      acc    <= '0;
      mv     <= '0;
      av     <= '0;
      fmul_x <= '0;
      fmul_y <= '0;
      fadd_x <= '0;
      fadd_y <= '0;
      result <= '0;
    end else begin
      mv <= mv_nxt;
      av <= av_nxt;
      if (state == IDLE && start) begin
        n_reg <= n_elems;
        acc   <= init_val;
        cnt   <= '0;
        cool  <= '0;
      end else begin
        if (accept) begin
          fmul_x <= in_x;
          fmul_y <= in_y;
          cnt    <= cnt_inc;
          cool   <= CD_INIT;
        end else if (cool != '0) begin
          cool <= cool - CD_W'(1);
        end
        if (mul_tap) begin
          fadd_x <= fmul_r;
          fadd_y <= acc;
        end
        if (add_tap) acc <= fadd_r;
      end
      if (state == DONE) result <= acc;
    end
  end

endmodule

// File: tb/tb_fmac_sched.sv
// Directed bench for fmac_sched with behavioural FloPoCo fmul/fadd pipelines around it.
module tb_fmac_sched;
  localparam int WE = 8, WF = 23, MUL_LAT = 2, ADD_LAT = 1, CNT_W = 16;
  localparam int W = WE + WF + 3;
  localparam int LAT_DONE = MUL_LAT + ADD_LAT + 3;
  localparam int II = ADD_LAT + 2;

  localparam logic [W-1:0] F_ZERO  = '0;
  localparam logic [W-1:0] F_HALF  = {2'b01, 1'b0, 8'd126, 23'h000000};
  localparam logic [W-1:0] F_ONE   = {2'b01, 1'b0, 8'd127, 23'h000000};
  localparam logic [W-1:0] F_TWO   = {2'b01, 1'b0, 8'd128, 23'h000000};
  localparam logic [W-1:0] F_THREE = {2'b01, 1'b0, 8'd128, 23'h400000};
  localparam logic [W-1:0] F_FOUR  = {2'b01, 1'b0, 8'd129, 23'h000000};
  localparam logic [W-1:0] F_4P5   = {2'b01, 1'b0, 8'd129, 23'h100000};
  localparam logic [W-1:0] F_7P5   = {2'b01, 1'b0, 8'd129, 23'h700000};

  logic             clk, reset, start, busy, in_valid, in_ready, done;
  logic [CNT_W-1:0] n_elems;
  logic [W-1:0]     init_val, in_x, in_y, fmul_x, fmul_y, fmul_r, fadd_x, fadd_y, fadd_r, result;

  fmac_sched #(.WE(WE), .WF(WF), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .n_elems(n_elems), .init_val(init_val),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .fmul_x(fmul_x), .fmul_y(fmul_y), .fmul_r(fmul_r),
    .fadd_x(fadd_x), .fadd_y(fadd_y), .fadd_r(fadd_r),
    .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [W-1:0] w);
    real r;
    int  e;
    if (w[W-1:W-2] != 2'b01) return 0.0;
    r = 1.0 + real'(w[WF-1:0]) / 8388608.0;
    e = int'(w[WE+WF-1:WF]) - 127;
    for (int i = 0; i < e; i++) r = r * 2.0;
    for (int i = 0; i > e; i--) r = r / 2.0;
    return w[WE+WF] ? -r : r;
  endfunction

  function automatic logic [W-1:0] r2f(input real r);
    logic [63:0] b;
    int          e;
    if (r == 0.0) return '0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {2'b01, b[63], e[7:0], b[51:29]};
  endfunction

  // External unit models: fmul result MUL_LAT cycles after its operands, fadd ADD_LAT.
  logic [W-1:0] mpipe [MUL_LAT] = '{default: '0};
  logic [W-1:0] apipe [ADD_LAT] = '{default: '0};
  always @(posedge clk) begin
    mpipe[0] <= r2f(f2r(fmul_x) * f2r(fmul_y));
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    apipe[0] <= r2f(f2r(fadd_x) + f2r(fadd_y));
    for (int i = 1; i < ADD_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign fmul_r = mpipe[MUL_LAT-1];
  assign fadd_r = apipe[ADD_LAT-1];

  int cyc = 0, acc_n = 0, done_n = 0, rdy_n = 0, done_t = 0, start_t = 0;
  int acc_t [256];
  always @(posedge clk) begin
    if (in_valid && in_ready) begin
      acc_t[acc_n[7:0]] <= cyc;
      acc_n <= acc_n + 1;
    end
    if (done) begin
      done_n <= done_n + 1;
      done_t <= cyc;
    end
    if (in_ready) rdy_n <= rdy_n + 1;
    if (start) start_t <= cyc;
    cyc <= cyc + 1;
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0]      init;
    logic [7:0]        n;
    logic [3:0][W-1:0] xs;
    logic [3:0][W-1:0] ys;
    logic [7:0]        gap;
    logic              hold;
    logic              poke;
    logic [W-1:0]      exp_res;
  } vec_t;

  function automatic vec_t mkvec(input logic [W-1:0] init, input int n,
                                 input logic [W-1:0] x0, y0, x1, y1, x2, y2, x3, y3,
                                 input int gap, input logic hold, input logic poke,
                                 input logic [W-1:0] exp_res);
    vec_t v;
    v.init = init; v.n = n[7:0];
    v.xs[0] = x0; v.ys[0] = y0; v.xs[1] = x1; v.ys[1] = y1;
    v.xs[2] = x2; v.ys[2] = y2; v.xs[3] = x3; v.ys[3] = y3;
    v.gap = gap[7:0]; v.hold = hold; v.poke = poke; v.exp_res = exp_res;
    return v;
  endfunction

  vec_t vecs [6];

  task automatic run_job(input vec_t v, input int idx);
    int  a0, d0, r0;
    logic ok;
    a0 = acc_n; d0 = done_n; r0 = rdy_n;
    @(negedge clk);
    start = 1'b1; n_elems = CNT_W'(v.n); init_val = v.init;
    in_valid = (v.n != 0); in_x = v.xs[0]; in_y = v.ys[0];
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < int'(v.n); k++) begin
      if (k > 0) begin
        if (v.gap != 0) begin
          in_valid = 1'b0;
          repeat (int'(v.gap)) @(negedge clk);
        end
        in_valid = 1'b1; in_x = v.xs[k]; in_y = v.ys[k];
      end
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (in_ready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      check($sformatf("job%0d_accept%0d_seen", idx, k), 64'(ok), 64'd1);
      @(negedge clk);
      if (k == int'(v.n) - 1) in_valid = v.hold;
      if (k == 0 && v.poke) begin
        start = 1'b1; n_elems = 5; init_val = F_7P5;
        @(negedge clk);
        start = 1'b0;
      end
    end
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done_n != d0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check($sformatf("job%0d_done_seen", idx), 64'(ok), 64'd1);
    check($sformatf("job%0d_result", idx), 64'(result), 64'(v.exp_res));
    check($sformatf("job%0d_busy_after_done", idx), 64'(busy), 64'd0);
    if (v.n == 0) begin
      check($sformatf("job%0d_done_latency", idx), 64'(done_t - start_t), 64'd1);
      check($sformatf("job%0d_ready_never", idx), 64'(rdy_n - r0), 64'd0);
    end else begin
      check($sformatf("job%0d_done_latency", idx), 64'(done_t - acc_t[(acc_n - 1) % 256]), 64'(LAT_DONE));
    end
    if (v.gap == 0)
      for (int k = 1; k < int'(v.n); k++)
        check($sformatf("job%0d_spacing%0d", idx, k), 64'(acc_t[a0 + k] - acc_t[a0 + k - 1]), 64'(II));
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("job%0d_accept_count", idx), 64'(acc_n - a0), 64'(v.n));
    check($sformatf("job%0d_done_count", idx), 64'(done_n - d0), 64'd1);
    check($sformatf("job%0d_result_held", idx), 64'(result), 64'(v.exp_res));
  endtask

  initial begin
    int   a0, d0;
    logic ok;
    reset = 1'b0; start = 1'b0; n_elems = '0; init_val = '0;
    in_valid = 1'b0; in_x = '0; in_y = '0;

    vecs[0] = mkvec(F_ZERO, 3, F_ONE, F_TWO, F_THREE, F_HALF, F_TWO, F_TWO, F_ZERO, F_ZERO, 0, 1'b0, 1'b0, F_7P5);
    vecs[1] = mkvec(F_FOUR, 0, F_ONE, F_ONE, F_ONE, F_ONE, F_ONE, F_ONE, F_ONE, F_ONE, 0, 1'b0, 1'b0, F_FOUR);
    vecs[2] = mkvec(F_ONE, 2, F_ONE, F_ONE, F_ONE, F_ONE, F_ZERO, F_ZERO, F_ZERO, F_ZERO, 5, 1'b0, 1'b0, F_THREE);
    vecs[3] = mkvec(F_HALF, 4, F_ONE, F_ONE, F_TWO, F_ONE, F_ONE, F_HALF, F_HALF, F_ONE, 0, 1'b0, 1'b0, F_4P5);
    vecs[4] = mkvec(F_ZERO, 2, F_ONE, F_TWO, F_ONE, F_TWO, F_ZERO, F_ZERO, F_ZERO, F_ZERO, 0, 1'b1, 1'b1, F_FOUR);
    vecs[5] = mkvec(F_ZERO, 1, F_TWO, F_TWO, F_ZERO, F_ZERO, F_ZERO, F_ZERO, F_ZERO, F_ZERO, 0, 1'b0, 1'b0, F_FOUR);

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_fmul_x", 64'(fmul_x), 64'd0);
    check("rst_fmul_y", 64'(fmul_y), 64'd0);
    check("rst_fadd_x", 64'(fadd_x), 64'd0);
    check("rst_fadd_y", 64'(fadd_y), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) run_job(vecs[i], i);

    // Reset with products still in flight, then a fresh job must be unaffected.
    a0 = acc_n; d0 = done_n;
    @(negedge clk);
    start = 1'b1; n_elems = 4; init_val = F_ZERO; in_valid = 1'b1; in_x = F_ONE; in_y = F_ONE;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (acc_n - a0 >= 2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("midrst_two_accepts", 64'(ok), 64'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_no_done", 64'(done_n - d0), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_fadd_x", 64'(fadd_x), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    run_job(vecs[5], 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
